vote_capture: RTL and testbench
===============================

Name: vote_capture

Overview:
- Front-end conditioner for the polling booth. It sits directly upstream of the per-candidate vote counters.
- Takes raw candidate push-buttons plus an official's ballot-arm button. Synchronises and debounces them.
- Enforces exactly one vote per armed ballot and emits single-cycle, mutually exclusive vote pulses that feed the counters' increment inputs.
- Rejects multi-press ballots, ballot timeouts and any voting after polls close.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synced candidate input must differ from its debounced level before that level flips. Legal range 2..65535.
- TIMEOUT_CYCLES, 1024: cycles an armed ballot waits for a press before it is voided. Legal range ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_ballot_arm  in  1  raw official button; a rising edge arms one ballot
- i_candidate_1  in  1  raw button, candidate 1
- i_candidate_2  in  1  raw button, candidate 2
- i_candidate_3  in  1  raw button, candidate 3
- i_over  in  1  polls closed; level-sensitive
- o_vote_1  out  1  one-cycle pulse, counted vote for candidate 1
- o_vote_2  out  1  one-cycle pulse, counted vote for candidate 2
- o_vote_3  out  1  one-cycle pulse, counted vote for candidate 3
- o_armed  out  1  ballot open, used for the voter lamp
- o_invalid  out  1  one-cycle pulse, multi-press ballot discarded
- o_timeout  out  1  one-cycle pulse, armed ballot expired

Behaviour:
- Single clock domain; clock port is clk, reset port is rst, rst is synchronous and active-high. On rst all outputs are 0, FSM goes to IDLE, synchronisers and debounced levels are 0, and all counters are 0.
- Every raw input passes through a 2-flop synchroniser.
- i_ballot_arm is edge-detected after sync only; it is not debounced.
- Candidate debounce: a per-input counter increments while synced != debounced and clears to 0 when they are equal. When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, the debounced level flips on the next edge and the counter clears.
- FSM states:
  - IDLE: o_armed=0. Arm rising edge with i_over=0 moves to ARMED and loads the timeout counter with 0.
  - ARMED: o_armed=1; the timeout counter increments each cycle.
    - Exactly one debounced candidate rising edge this cycle: go to CAST and latch its index.
    - Two or more rising edges in the same cycle, or a rising edge while another debounced level is already high: go to RELEASE and pulse o_invalid.
    - Counter reaches TIMEOUT_CYCLES-1 with no edge: pulse o_timeout and go to IDLE.
    - The press check takes priority over the timeout check in the same cycle.
  - CAST: the latched o_vote_n is high for exactly this one cycle; next state is RELEASE.
  - RELEASE: stay until all three debounced levels are 0, then go to IDLE.
- Arm edges in ARMED, CAST or RELEASE are ignored; they are not queued.
- i_over=1 takes priority over everything: from any state go to IDLE next cycle with no vote pulse.
- If i_over rises in the same cycle as a single valid edge in ARMED, the vote is dropped. Votes are only counted before close.
- Latency: a raw press held stable produces o_vote_n exactly 2 + DEBOUNCE_CYCLES + 1 cycles after the first edge that samples it high. This is 19 cycles at the default.
- Held buttons never re-vote, because RELEASE requires a full release.
- At most one o_vote_n is high in any cycle.
- rst mid-ballot discards that ballot.

Optional Feature:
- Macro: VOTE_CAPTURE_BALLOT_STATS_EN.
- When defined:
  - Adds outputs o_ballots_cast [31:0], o_ballots_invalid [31:0] and o_ballots_timeout [31:0].
  - Each counter increments on the CAST, o_invalid and o_timeout events respectively.
  - All three reset to 0 on rst and saturate at 32'hFFFF_FFFF; no wrap.
- When undefined: these ports and their registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package polling_pkg holds:
  - the FSM enum (IDLE, ARMED, CAST, RELEASE);
  - NUM_CAND = 3;
  - the CNT_W = 32 counter width shared with the downstream counters;
  - the stats saturation constant.
- One natural sub-module, vote_debounce, containing the synchroniser, debounce counter and rising-edge output. It is instantiated three times, once per candidate.

Test Plan:
- Arm, then hold i_candidate_2 high for 40 cycles → o_vote_2 is a single pulse 19 cycles after press (default parameters); o_vote_1, o_vote_3 and o_invalid stay 0; FSM returns to IDLE after release.
- Bounce i_candidate_1 with a 5-cycle-high / 3-cycle-low pattern for 60 cycles, then hold high → no pulse during bouncing; exactly one o_vote_1 pulse 19 cycles after the stable press.
- Arm, then press candidates 1 and 3 on the same edge → one o_invalid pulse and no o_vote_*; after both are released the next arm is accepted.
- Arm with TIMEOUT_CYCLES=8 and no press → o_timeout pulses 8 cycles after o_armed rises, then o_armed=0; a later press yields no vote.
- Hold i_candidate_3 high, arm twice without releasing → exactly one o_vote_3 pulse total.
- Assert i_over while ARMED, then arm and press → no vote pulses and o_armed=0. Assert rst mid-ARMED → all outputs 0 on the next cycle. With VOTE_CAPTURE_BALLOT_STATS_EN, three valid ballots plus one invalid give o_ballots_cast=3 and o_ballots_invalid=1.

Source files
------------

// File: rtl/polling_pkg.sv
// Shared polling-booth definitions: ballot FSM states, candidate count and the
// counter width/saturation used by the vote and ballot statistics counters.
package polling_pkg;

   localparam int NUM_CAND = 3;
   localparam int CNT_W    = 32;

   localparam logic [CNT_W-1:0] STATS_SAT = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAST    = 2'd2,
      RELEASE = 2'd3
   } vote_state_t;

   // Saturating increment; statistics must stick at all-ones rather than wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      sat_inc = (value == STATS_SAT) ? value : value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/vote_debounce.sv
// One candidate button: 2-flop synchroniser, debounce counter and a registered
// rising-edge pulse aligned with the delayed level it reports.
module vote_debounce
   import polling_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   logic        sync_1;
   logic        sync_2;
   logic        deb;
   logic        deb_d;
   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         deb    <= 1'b0;
         deb_d  <= 1'b0;
         rise   <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         deb_d  <= deb;
         rise   <= deb & ~deb_d;
         if (sync_2 == deb) begin
            cnt <= '0;
         end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
            deb <= ~deb;
            cnt <= '0;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

   // Report the delayed level so it lines up with the registered rise pulse.
   assign level = deb_d;

endmodule

// File: rtl/vote_capture.sv
// Polling-booth front end: arms one ballot per official press, emits one vote
// pulse per valid ballot. Optional counters: VOTE_CAPTURE_BALLOT_STATS_EN.
module vote_capture
   import polling_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_ballot_arm,
   input  logic i_candidate_1,
   input  logic i_candidate_2,
   input  logic i_candidate_3,
   input  logic i_over,
   output logic o_vote_1,
   output logic o_vote_2,
   output logic o_vote_3,
   output logic o_armed,
   output logic o_invalid,
   output logic o_timeout
`ifdef VOTE_CAPTURE_BALLOT_STATS_EN
   ,
   output logic [CNT_W-1:0] o_ballots_cast,
   output logic [CNT_W-1:0] o_ballots_invalid,
   output logic [CNT_W-1:0] o_ballots_timeout
`endif
);

   logic                arm_s1, arm_s2, arm_d;
   logic                over_s1, over_s2;
   logic [NUM_CAND-1:0] cand_raw, cand_lvl, cand_rise;
   logic [NUM_CAND-1:0] cast_sel, cast_sel_n;
   vote_state_t         state, state_n;
   logic [CNT_W-1:0]    tcnt, tcnt_n;
   logic                arm_rise, press_any, press_bad;
   logic                invalid_n, timeout_n;

   assign cand_raw = {i_candidate_3, i_candidate_2, i_candidate_1};

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_cand
      vote_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
         .clk   (clk),
         .rst   (rst),
         .raw   (cand_raw[g]),
         .level (cand_lvl[g]),
         .rise  (cand_rise[g])
      );
   end

   // The arm button is only synchronised and edge-detected; the official's press is trusted.
   always_ff @(posedge clk) begin
      if (rst) begin
         arm_s1  <= 1'b0;
         arm_s2  <= 1'b0;
         arm_d   <= 1'b0;
         over_s1 <= 1'b0;
         over_s2 <= 1'b0;
      end else begin
         arm_s1  <= i_ballot_arm;
         arm_s2  <= arm_s1;
         arm_d   <= arm_s2;
         over_s1 <= i_over;
         over_s2 <= over_s1;
      end
   end

   assign arm_rise  = arm_s2 & ~arm_d;
   assign press_any = |cand_rise;
   assign press_bad = ($countones(cand_rise) > 1) || (|(cand_lvl & ~cand_rise));

   always_comb begin
      state_n    = state;
      tcnt_n     = tcnt;
      cast_sel_n = cast_sel;
      invalid_n  = 1'b0;
      timeout_n  = 1'b0;
      if (over_s2) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (arm_rise) begin
                  state_n = ARMED;
                  tcnt_n  = '0;
               end
            end
            ARMED: begin
               tcnt_n = tcnt + CNT_W'(1);
               if (press_any) begin
                  if (press_bad) begin
                     state_n   = RELEASE;
                     invalid_n = 1'b1;
                  end else begin
                     state_n    = CAST;
                     cast_sel_n = cand_rise;
                  end
               end else if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_n   = IDLE;
                  timeout_n = 1'b1;
               end
            end
            CAST:    state_n = RELEASE;
            RELEASE: if (cand_lvl == '0) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tcnt      <= '0;
         cast_sel  <= '0;
         o_invalid <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         state     <= state_n;
         tcnt      <= tcnt_n;
         cast_sel  <= cast_sel_n;
         o_invalid <= invalid_n;
         o_timeout <= timeout_n;
      end
   end

   assign o_armed  = (state == ARMED);
   assign o_vote_1 = (state == CAST) & cast_sel[0];
   assign o_vote_2 = (state == CAST) & cast_sel[1];
   assign o_vote_3 = (state == CAST) & cast_sel[2];

`ifdef VOTE_CAPTURE_BALLOT_STATS_EN
   // CAST is only ever entered from ARMED, so state_n == CAST marks a new ballot.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_ballots_cast    <= '0;
         o_ballots_invalid <= '0;
         o_ballots_timeout <= '0;
      end else begin
         if (state_n == CAST) o_ballots_cast    <= sat_inc(o_ballots_cast);
         if (invalid_n)       o_ballots_invalid <= sat_inc(o_ballots_invalid);
         if (timeout_n)       o_ballots_timeout <= sat_inc(o_ballots_timeout);
      end
   end
`endif

endmodule

// File: tb/tb_vote_capture.sv
// Bench for vote_capture: directed scenarios plus random button traffic checked
// every cycle against a history-window reference model, on two timeout settings.
module tb_vote_capture;
   import polling_pkg::*;

   localparam int DEB     = 16;
   localparam int T_LONG  = 1024;
   localparam int T_SHORT = 8;
   localparam int LAT     = 2 + DEB + 1;
   localparam int HLEN    = DEB + 3;

   localparam int P_CLOSED  = 0;
   localparam int P_OPEN    = 1;
   localparam int P_COUNTED = 2;
   localparam int P_DRAIN   = 3;

   // ---------------- clock / reset / stimulus signals ----------------
   logic clk = 1'b0;
   logic rst, arm, c1, c2, c3, over;
   always #5 clk = ~clk;

   logic o_vote_1_l, o_vote_2_l, o_vote_3_l, o_armed_l, o_invalid_l, o_timeout_l;
   logic o_vote_1_s, o_vote_2_s, o_vote_3_s, o_armed_s, o_invalid_s, o_timeout_s;
`ifdef VOTE_CAPTURE_BALLOT_STATS_EN
   logic [31:0] cast_l, inv_l, to_l, cast_s, inv_s, to_s;
`endif

   vote_capture #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(T_LONG)) dut (
      .clk(clk), .rst(rst), .i_ballot_arm(arm),
      .i_candidate_1(c1), .i_candidate_2(c2), .i_candidate_3(c3), .i_over(over),
      .o_vote_1(o_vote_1_l), .o_vote_2(o_vote_2_l), .o_vote_3(o_vote_3_l),
      .o_armed(o_armed_l), .o_invalid(o_invalid_l), .o_timeout(o_timeout_l)
`ifdef VOTE_CAPTURE_BALLOT_STATS_EN
      , .o_ballots_cast(cast_l), .o_ballots_invalid(inv_l), .o_ballots_timeout(to_l)
`endif
   );

   vote_capture #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(T_SHORT)) dut_s (
      .clk(clk), .rst(rst), .i_ballot_arm(arm),
      .i_candidate_1(c1), .i_candidate_2(c2), .i_candidate_3(c3), .i_over(over),
      .o_vote_1(o_vote_1_s), .o_vote_2(o_vote_2_s), .o_vote_3(o_vote_3_s),
      .o_armed(o_armed_s), .o_invalid(o_invalid_s), .o_timeout(o_timeout_s)
`ifdef VOTE_CAPTURE_BALLOT_STATS_EN
      , .o_ballots_cast(cast_s), .o_ballots_invalid(inv_s), .o_ballots_timeout(to_s)
`endif
   );

   logic [5:0] obs_l, obs_s;
   assign obs_l = {o_vote_3_l, o_vote_2_l, o_vote_1_l, o_armed_l, o_invalid_l, o_timeout_l};
   assign obs_s = {o_vote_3_s, o_vote_2_s, o_vote_1_s, o_armed_s, o_invalid_s, o_timeout_s};

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Raw input history {over,arm,c3,c2,c1}; hist[k] was sampled k+1 edges ago.
   logic [4:0] hist [HLEN];
   logic [2:0] lvl_h [3];
   bit         model_valid = 0;
   int         phase [2];
   int         waited [2];
   int         who [2];
   bit         e_inv [2];
   bit         e_to [2];
   int         n_cast [2];
   int         n_inv [2];
   int         n_to [2];
   logic [1:0] exp_q [$];

   function automatic int tmo(input int t);
      tmo = (t == 0) ? T_LONG : T_SHORT;
   endfunction

   task automatic model_step();
      logic [2:0] rise, lv, nxt;
      logic       os, ar, all_diff;
      int         nr;
      if (rst) begin
         model_valid = 1;
         for (int k = 0; k < HLEN; k++) hist[k] = '0;
         for (int k = 0; k < 3; k++) lvl_h[k] = '0;
         for (int t = 0; t < 2; t++) begin
            phase[t] = P_CLOSED; waited[t] = 0; who[t] = 0;
            e_inv[t] = 0; e_to[t] = 0; n_cast[t] = 0; n_inv[t] = 0; n_to[t] = 0;
         end
         return;
      end
      if (!model_valid) return;
      // A debounced rise becomes visible to the ballot logic two edges after the level flips.
      rise = lvl_h[1] & ~lvl_h[2];
      lv   = lvl_h[1];
      os   = hist[1][4];
      ar   = hist[1][3] & ~hist[2][3];
      nr   = $countones(rise);
      for (int t = 0; t < 2; t++) begin
         e_inv[t] = 0;
         e_to[t]  = 0;
         if (os) begin
            phase[t] = P_CLOSED;
         end else begin
            case (phase[t])
               P_CLOSED: if (ar) begin phase[t] = P_OPEN; waited[t] = 0; end
               P_OPEN: begin
                  if (nr > 0) begin
                     if (nr > 1 || (lv & ~rise) != 3'b000) begin
                        phase[t] = P_DRAIN; e_inv[t] = 1; n_inv[t]++;
                     end else begin
                        phase[t] = P_COUNTED;
                        who[t] = (rise == 3'b001) ? 0 : (rise == 3'b010) ? 1 : 2;
                        n_cast[t]++;
                        if (t == 0) exp_q.push_back(2'(who[t]));
                     end
                  end else if (waited[t] == tmo(t) - 1) begin
                     phase[t] = P_CLOSED; e_to[t] = 1; n_to[t]++;
                  end else begin
                     waited[t]++;
                  end
               end
               P_COUNTED: phase[t] = P_DRAIN;
               default:   if (lv == 3'b000) phase[t] = P_CLOSED;
            endcase
         end
      end
      // A level flips once the last DEB synchronised samples all disagree with it.
      nxt = lvl_h[0];
      for (int i = 0; i < 3; i++) begin
         all_diff = 1'b1;
         for (int k = 1; k <= DEB; k++) if (hist[k][i] == lvl_h[0][i]) all_diff = 1'b0;
         if (all_diff) nxt[i] = ~lvl_h[0][i];
      end
      for (int k = HLEN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0]  = {over, arm, c3, c2, c1};
      lvl_h[2] = lvl_h[1];
      lvl_h[1] = lvl_h[0];
      lvl_h[0] = nxt;
   endtask

   function automatic logic [5:0] model_outs(input int t);
      model_outs = {phase[t] == P_COUNTED && who[t] == 2, phase[t] == P_COUNTED && who[t] == 1,
                    phase[t] == P_COUNTED && who[t] == 0, phase[t] == P_OPEN, e_inv[t], e_to[t]};
   endfunction

   // ---------------- observed-event tallies for directed checks ----------------
   int vote_cnt_l [3];
   int vote_cyc_l [3];
   int vote_cnt_s [3];
   int inv_cnt_l, to_cnt_s, to_cyc_s, arm_cyc_s;
   logic prev_armed_s = 1'b0;

   task automatic clear_tally();
      for (int i = 0; i < 3; i++) begin vote_cnt_l[i] = 0; vote_cyc_l[i] = -1; vote_cnt_s[i] = 0; end
      inv_cnt_l = 0; to_cnt_s = 0; to_cyc_s = -1; arm_cyc_s = -1000;
   endtask

   task automatic compare();
      logic [1:0] idx;
      if (!model_valid) return;
      check("outs_long", 32'(obs_l), 32'(model_outs(0)));
      check("outs_short", 32'(obs_s), 32'(model_outs(1)));
`ifdef VOTE_CAPTURE_BALLOT_STATS_EN
      check("cast_long", cast_l, 32'(n_cast[0]));
      check("inv_long", inv_l, 32'(n_inv[0]));
      check("to_long", to_l, 32'(n_to[0]));
      check("cast_short", cast_s, 32'(n_cast[1]));
      check("inv_short", inv_s, 32'(n_inv[1]));
      check("to_short", to_s, 32'(n_to[1]));
`endif
      if (obs_l[5:3] != 3'b000) begin
         if (exp_q.size() == 0) begin
            check("vote_unexpected", 32'(obs_l[5:3]), 32'd0);
         end else begin
            idx = exp_q.pop_front();
            check("vote_idx", 32'(obs_l[5:3]), 32'(3'b001 << idx));
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (obs_l[3+i] === 1'b1) begin vote_cnt_l[i]++; vote_cyc_l[i] = cyc; end
         if (obs_s[3+i] === 1'b1) vote_cnt_s[i]++;
      end
      if (o_invalid_l === 1'b1) inv_cnt_l++;
      if (o_timeout_s === 1'b1) begin to_cnt_s++; to_cyc_s = cyc; end
      if (o_armed_s === 1'b1 && prev_armed_s !== 1'b1) arm_cyc_s = cyc;
      prev_armed_s = o_armed_s;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic arm_pulse();
      arm = 1'b1; idle(3);
      arm = 1'b0; idle(3);
   endtask

   task automatic set_cand(input int k, input logic v);
      case (k)
         0:       c1 = v;
         1:       c2 = v;
         default: c3 = v;
      endcase
   endtask

   // ---------------- main sequence ----------------
   int t0, len, pick;

   initial begin
      rst = 1'b1; arm = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0; over = 1'b0;
      clear_tally();
      idle(3);
      check("reset_outs_long", 32'(obs_l), 32'd0);
      check("reset_outs_short", 32'(obs_s), 32'd0);
      rst = 1'b0;
      idle(4);

      // Single held press: one vote, fixed latency, back to IDLE after release.
      arm_pulse();
      check("s1_armed", 32'(o_armed_l), 32'd1);
      clear_tally();
      c2 = 1'b1; t0 = cyc + 1; idle(40);
      c2 = 1'b0; idle(DEB + 8);
      check("s1_latency", 32'(vote_cyc_l[1] - t0), 32'(LAT));
      check("s1_vote2_count", 32'(vote_cnt_l[1]), 32'd1);
      check("s1_other_events", 32'(vote_cnt_l[0] + vote_cnt_l[2] + inv_cnt_l), 32'd0);
      check("s1_state_idle", 32'(dut.state), 32'(IDLE));

      // Bouncing contact, then a stable press.
      arm_pulse();
      clear_tally();
      for (int p = 0; p < 7; p++) begin c1 = 1'b1; idle(5); c1 = 1'b0; idle(3); end
      check("s2_bounce_quiet", 32'(vote_cnt_l[0] + inv_cnt_l), 32'd0);
      c1 = 1'b1; t0 = cyc + 1; idle(30);
      c1 = 1'b0; idle(DEB + 8);
      check("s2_latency", 32'(vote_cyc_l[0] - t0), 32'(LAT));
      check("s2_vote1_count", 32'(vote_cnt_l[0]), 32'd1);

      // Two candidates on the same edge.
      arm_pulse();
      clear_tally();
      c1 = 1'b1; c3 = 1'b1; idle(30);
      check("s3_invalid_count", 32'(inv_cnt_l), 32'd1);
      check("s3_no_votes", 32'(vote_cnt_l[0] + vote_cnt_l[1] + vote_cnt_l[2]), 32'd0);
      c1 = 1'b0; c3 = 1'b0; idle(DEB + 8);
      arm_pulse();
      check("s3_rearm", 32'(o_armed_l), 32'd1);
      over = 1'b1; idle(4); over = 1'b0; idle(2);

      // Timeout on the short-timeout instance; the long one still counts the press.
      clear_tally();
      arm_pulse();
      idle(12);
      check("s4_timeout_delay", 32'(to_cyc_s - arm_cyc_s), 32'(T_SHORT));
      check("s4_timeout_count", 32'(to_cnt_s), 32'd1);
      check("s4_short_closed", 32'(o_armed_s), 32'd0);
      c1 = 1'b1; idle(30); c1 = 1'b0; idle(DEB + 8);
      check("s4_short_no_vote", 32'(vote_cnt_s[0] + vote_cnt_s[1] + vote_cnt_s[2]), 32'd0);
      check("s4_long_vote", 32'(vote_cnt_l[0]), 32'd1);

      // Held button across two arm presses.
      clear_tally();
      c3 = 1'b1; idle(5);
      arm_pulse(); idle(30);
      arm_pulse(); idle(30);
      check("s5_vote3_once", 32'(vote_cnt_l[2]), 32'd1);
      check("s5_second_arm_ignored", 32'(o_armed_l), 32'd0);
      c3 = 1'b0; idle(DEB + 8);

      // Polls closed.
      clear_tally();
      arm_pulse();
      over = 1'b1; idle(4);
      check("s6_closed", 32'(o_armed_l), 32'd0);
      arm_pulse(); c2 = 1'b1; idle(30);
      check("s6_no_votes", 32'(vote_cnt_l[0] + vote_cnt_l[1] + vote_cnt_l[2]), 32'd0);
      check("s6_not_armed", 32'(o_armed_l), 32'd0);
      c2 = 1'b0; over = 1'b0; idle(DEB + 8);

      // Reset in the middle of an armed ballot.
      arm_pulse();
      rst = 1'b1; idle(1);
      check("s7_rst_long", 32'(obs_l), 32'd0);
      check("s7_rst_short", 32'(obs_s), 32'd0);
      rst = 1'b0; idle(3);

      // Three valid ballots and one invalid one.
      clear_tally();
      for (int k = 0; k < 3; k++) begin
         arm_pulse(); set_cand(k, 1'b1); idle(25); set_cand(k, 1'b0); idle(DEB + 8);
      end
      arm_pulse(); c1 = 1'b1; c2 = 1'b1; idle(25); c1 = 1'b0; c2 = 1'b0; idle(DEB + 8);
      check("s8_votes", 32'(vote_cnt_l[0] + vote_cnt_l[1] + vote_cnt_l[2]), 32'd3);
      check("s8_invalid", 32'(inv_cnt_l), 32'd1);
`ifdef VOTE_CAPTURE_BALLOT_STATS_EN
      check("s8_stats_cast", cast_l, 32'd3);
      check("s8_stats_invalid", inv_l, 32'd1);
      check("s8_stats_timeout", to_l, 32'd0);
`endif

      // Random traffic: held segments with occasional arm, close and reset.
      for (int ep = 0; ep < 220; ep++) begin
         len  = $urandom_range(1, 45);
         pick = $urandom_range(0, 9);
         arm  = ($urandom_range(0, 2) == 0);
         over = ($urandom_range(0, 24) == 0);
         case (pick)
            1:       {c3, c2, c1} = 3'b001;
            2:       {c3, c2, c1} = 3'b010;
            3:       {c3, c2, c1} = 3'b100;
            5:       {c3, c2, c1} = 3'b101;
            6:       {c3, c2, c1} = 3'b011;
            7:       {c3, c2, c1} = 3'($urandom_range(0, 7));
            8:       ;
            default: {c3, c2, c1} = 3'b000;
         endcase
         if ($urandom_range(0, 60) == 0) begin rst = 1'b1; idle(1); rst = 1'b0; end
         idle(len);
      end

      arm = 1'b0; over = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
      idle(DEB + 10);
      check("vote_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
